alarm_responder: RTL and testbench

//  Consumer side of the clock's alarm-match interface. It watches time (tmin/thrs) against
//  the alarm setting (amin/ahrs) and owns the buzzer: ring, snooze, stop and auto-timeout.
//  It sits beside the clock top-level and replaces the raw combinational match-to-Buzz

---
 rtl/alarm_pkg.sv | 11 +
 rtl/alarm_sec_timer.sv | 26 ++
 rtl/alarm_responder.sv | 134 +++++++++++++
 tb/tb_alarm_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding for the alarm responder
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } alarm_st_t;

endpackage

// File: rtl/alarm_sec_timer.sv
// rtl/alarm_sec_timer.sv - seconds counter with load/up/down, shared by ring timeout and snooze countdown
module alarm_sec_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (up) begin
            value <= value + W'(1);
        end else if (down) begin
            value <= value - W'(1);
        end
    end

endmodule

// File: rtl/alarm_responder.sv
// rtl/alarm_responder.sv - registered alarm FSM owning the buzzer: ring, snooze, stop, auto-timeout
module alarm_responder #(
    parameter int NS         = 60,
    parameter int RING_S     = 60,
    parameter int SNOOZE_S   = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(NS):0]                 tmin,
    input  logic [$clog2(NS):0]                 thrs,
    input  logic [$clog2(NS):0]                 amin,
    input  logic [$clog2(NS):0]                 ahrs,
    input  logic                                alarmon,
    input  logic                                snooze,
    input  logic                                stop,
    output logic                                buzz,
    output logic                                snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]     snooze_cnt
);

    import alarm_pkg::*;

    localparam int CW   = $clog2(MAX_SNOOZE + 1);
    localparam int TMAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] RING_LAST   = TW'(RING_S - 1);
    localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_S - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_SNOOZE);

    alarm_st_t      state;
    alarm_st_t      state_d;
    logic [CW-1:0]  cnt_d;
    logic           match;
    logic           match_q;
    logic           rise;
    logic           armed;
    logic           t_load;
    logic [TW-1:0]  t_val;
    logic           t_up;
    logic           t_down;
    logic [TW-1:0]  timer;

    assign match = (tmin == amin) && (thrs == ahrs);
    assign rise  = match && !match_q;

    alarm_sec_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .up       (t_up),
        .down     (t_down),
        .value    (timer)
    );

    // A ring period accepts snooze only after the button was seen released inside it,
    // so a held button cannot chain straight through a re-ring.
    always_comb begin
        state_d = state;
        cnt_d   = snooze_cnt;
        t_load  = 1'b0;
        t_val   = '0;
        t_up    = 1'b0;
        t_down  = 1'b0;
        if (!alarmon) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_d = RING;
                        t_load  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                RING: begin
                    if (stop) begin
                        state_d = DONE;
                    end else if (snooze && armed && (snooze_cnt < CNT_MAX)) begin
                        state_d = SNOOZE;
                        t_load  = 1'b1;
                        t_val   = SNOOZE_LOAD;
                        cnt_d   = snooze_cnt + CW'(1);
                    end else if (timer == RING_LAST) begin
                        state_d = DONE;
                    end else begin
                        t_up = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_d = DONE;
                    end else if (timer == '0) begin
                        state_d = RING;
                        t_load  = 1'b1;
                    end else begin
                        t_down = 1'b1;
                    end
                end
                DONE: begin
                    if (!match) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // match_q resets high so power-up with time already equal to alarm does not ring.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            buzz       <= 1'b0;
            snoozing   <= 1'b0;
            snooze_cnt <= '0;
            match_q    <= 1'b1;
            armed      <= 1'b0;
        end else begin
            state      <= state_d;
            buzz       <= (state_d == RING);
            snoozing   <= (state_d == SNOOZE);
            snooze_cnt <= cnt_d;
            match_q    <= match;
            armed      <= (state == RING) && (armed || !snooze);
        end
    end

endmodule

// File: tb/tb_alarm_responder.sv
// tb/tb_alarm_responder.sv - scoreboard bench for alarm_responder
module tb_alarm_responder;

    logic       clk;
    logic       rst;
    logic [6:0] tmin;
    logic [6:0] thrs;
    logic [6:0] amin;
    logic [6:0] ahrs;
    logic       alarmon;
    logic       snooze;
    logic       stop;
    logic       buzz;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    typedef struct packed {
        logic       b;
        logic       s;
        logic [1:0] c;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    alarm_responder #(
        .NS         (60),
        .RING_S     (4),
        .SNOOZE_S   (3),
        .MAX_SNOOZE (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tmin       (tmin),
        .thrs       (thrs),
        .amin       (amin),
        .ahrs       (ahrs),
        .alarmon    (alarmon),
        .snooze     (snooze),
        .stop       (stop),
        .buzz       (buzz),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".buzz"}, int'(buzz), int'(e.b));
            check({t, ".snoozing"}, int'(snoozing), int'(e.s));
            check({t, ".snooze_cnt"}, int'(snooze_cnt), int'(e.c));
        end
    endtask

    task automatic expect_now(input logic eb, input logic es, input logic [1:0] ec,
                              input string tag);
        exp_q.push_back('{b: eb, s: es, c: ec});
        tag_q.push_back(tag);
        #1;
        compare_head();
    endtask

    task automatic step(input logic [6:0] h, input logic [6:0] m, input logic on,
                        input logic sn, input logic st,
                        input logic eb, input logic es, input logic [1:0] ec,
                        input string tag);
        thrs    = h;
        tmin    = m;
        alarmon = on;
        snooze  = sn;
        stop    = st;
        exp_q.push_back('{b: eb, s: es, c: ec});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        ahrs    = 7'd7;
        amin    = 7'd30;
        thrs    = 7'd7;
        tmin    = 7'd29;
        alarmon = 1'b1;
        snooze  = 1'b0;
        stop    = 1'b0;
        #2;
        rst = 1'b0;
        expect_now(1'b0, 1'b0, 2'd0, "rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // plain ring and timeout
        step(7, 29, 1, 0, 0, 0, 0, 2'd0, "s1.pre");
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s1.r0");
        for (int i = 1; i < 4; i++) step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s1.ring");
        step(7, 30, 1, 0, 0, 0, 0, 2'd0, "s1.tmo");
        step(7, 30, 1, 0, 0, 0, 0, 2'd0, "s1.done");
        step(7, 31, 1, 0, 0, 0, 0, 2'd0, "s1.idle");

        // snooze, held button across re-ring, re-ring spans next minute
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s2.r0");
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s2.r1");
        step(7, 30, 1, 1, 0, 0, 1, 2'd1, "s2.snz");
        step(7, 31, 1, 1, 0, 0, 1, 2'd1, "s2.z1");
        step(7, 31, 1, 1, 0, 0, 1, 2'd1, "s2.z2");
        step(7, 31, 1, 1, 0, 1, 0, 2'd1, "s2.rering");
        step(7, 31, 1, 1, 0, 1, 0, 2'd1, "s2.held");

        // second snooze, third ignored, then timeout
        step(7, 31, 1, 0, 0, 1, 0, 2'd1, "s3.arm");
        step(7, 31, 1, 1, 0, 0, 1, 2'd2, "s3.snz2");
        step(7, 31, 1, 0, 0, 0, 1, 2'd2, "s3.z1");
        step(7, 31, 1, 0, 0, 0, 1, 2'd2, "s3.z2");
        step(7, 31, 1, 0, 0, 1, 0, 2'd2, "s3.rering");
        step(7, 31, 1, 0, 0, 1, 0, 2'd2, "s3.arm2");
        step(7, 31, 1, 1, 0, 1, 0, 2'd2, "s3.ignored");
        step(7, 31, 1, 0, 0, 1, 0, 2'd2, "s3.r3");
        step(7, 31, 1, 0, 0, 0, 0, 2'd2, "s3.tmo");
        step(7, 32, 1, 0, 0, 0, 0, 2'd2, "s3.idle");

        // stop beats snooze
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s4.r0");
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s4.arm");
        step(7, 30, 1, 1, 1, 0, 0, 2'd0, "s4.stop");
        step(7, 30, 1, 0, 0, 0, 0, 2'd0, "s4.done");

        // alarmon dropped during snooze
        step(7, 31, 1, 0, 0, 0, 0, 2'd0, "s6.idle");
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s6.r0");
        step(7, 30, 1, 0, 0, 1, 0, 2'd0, "s6.arm");
        step(7, 30, 1, 1, 0, 0, 1, 2'd1, "s6.snz");
        step(7, 30, 0, 0, 0, 0, 0, 2'd0, "s6.off");
        for (int i = 0; i < 4; i++) step(7, 30, 0, 0, 0, 0, 0, 2'd0, "s6.quiet");
        step(7, 30, 1, 0, 0, 0, 0, 2'd0, "s6.on");
        step(7, 30, 1, 0, 0, 0, 0, 2'd0, "s6.on2");

        // reset at 00:00 with alarm 00:00, then async reset mid-ring
        ahrs = 7'd0;
        amin = 7'd0;
        thrs = 7'd0;
        tmin = 7'd0;
        rst  = 1'b0;
        expect_now(1'b0, 1'b0, 2'd0, "s5.rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 2'd0, "s5.noring");
        step(0, 1, 1, 0, 0, 0, 0, 2'd0, "s5.away");
        step(0, 0, 1, 0, 0, 1, 0, 2'd0, "s5.r0");
        step(0, 0, 1, 0, 0, 1, 0, 2'd0, "s5.r1");
        rst = 1'b0;
        expect_now(1'b0, 1'b0, 2'd0, "s5.async");
        #2;
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
